// File: rtl/ram_stream_reader.sv
// Streams a burst of words out of a registered-read RAM into a ready/valid port.
// Define RAM_STREAM_CLEAR_EN to add a CLEAR state that fills a RAM range with a constant.
module ram_stream_reader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] startAddr,
    input  logic [ADDRESS_WIDTH:0]   length,
    input  logic                     abort,
`ifdef RAM_STREAM_CLEAR_EN
    input  logic                     clearReq,
    input  logic [DATA_WIDTH-1:0]    clearData,
`endif
    output logic [ADDRESS_WIDTH-1:0] ramAddr,
    output logic                     ramWEn,
    output logic [DATA_WIDTH-1:0]    ramDataIn,
    input  logic [DATA_WIDTH-1:0]    ramDataOut,
    output logic [DATA_WIDTH-1:0]    outData,
    output logic                     outValid,
    input  logic                     outReady,
    output logic                     busy,
    output logic                     done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 4);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH:0]   LEN_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]         PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]         CAPACITY = CNT_W'(FIFO_DEPTH);

`ifdef RAM_STREAM_CLEAR_EN
    typedef enum logic [1:0] {IDLE, READ, DRAIN, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
`endif

    state_t                 state;
    logic [ADDRESS_WIDTH:0] remain;
    logic                   issueStage;
    logic                   returnStage;
    logic [DATA_WIDTH-1:0]  fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wrPtr;
    logic [PTR_W-1:0]       rdPtr;
    logic [CNT_W-1:0]       fifoCount;
    logic [CNT_W-1:0]       load;
    logic                   pop;
    logic                   outFree;
    logic                   take;
    logic                   push;
    logic                   canIssue;

    // The output register is one extra slot behind the FIFO, which is what lets
    // a 2-deep buffer cover the 2-cycle RAM round trip at full throughput.
    assign pop      = outValid && outReady;
    assign outFree  = !outValid || pop;
    assign take     = outFree && (fifoCount != '0);
    assign push     = returnStage && !(outFree && (fifoCount == '0));
    assign load     = fifoCount + CNT_W'(outValid) + CNT_W'(issueStage)
                    + CNT_W'(returnStage) - CNT_W'(pop);
    assign canIssue = (load <= CAPACITY);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= ramDataOut;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            outValid  <= 1'b0;
            outData   <= '0;
        end else if (abort) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            outValid  <= 1'b0;
        end else begin
            if (outFree) begin
                if (fifoCount != '0) begin
                    outData  <= fifoMem[rdPtr];
                    outValid <= 1'b1;
                    rdPtr    <= rdPtr + PTR_ONE;
                end else if (returnStage) begin
                    outData  <= ramDataOut;
                    outValid <= 1'b1;
                end else begin
                    outValid <= 1'b0;
                end
            end
            if (push) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            fifoCount <= fifoCount + CNT_W'(push) - CNT_W'(take);
        end
    end

`ifdef RAM_STREAM_CLEAR_EN
    logic                  wenReg;
    logic [DATA_WIDTH-1:0] wdataReg;
    assign ramWEn    = wenReg;
    assign ramDataIn = wdataReg;
`else
    assign ramWEn    = 1'b0;
    assign ramDataIn = '0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            remain      <= '0;
            ramAddr     <= '0;
            issueStage  <= 1'b0;
            returnStage <= 1'b0;
            done        <= 1'b0;
`ifdef RAM_STREAM_CLEAR_EN
            wenReg      <= 1'b0;
            wdataReg    <= '0;
`endif
        end else begin
            done        <= 1'b0;
            issueStage  <= 1'b0;
            returnStage <= issueStage;
            if (abort) begin
                state       <= IDLE;
                remain      <= '0;
                returnStage <= 1'b0;
`ifdef RAM_STREAM_CLEAR_EN
                wenReg      <= 1'b0;
                wdataReg    <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (length == '0) begin
                                done <= 1'b1;
                            end else begin
                                ramAddr    <= startAddr;
                                issueStage <= 1'b1;
                                remain     <= length - LEN_ONE;
                                state      <= (length == LEN_ONE) ? DRAIN : READ;
                            end
`ifdef RAM_STREAM_CLEAR_EN
                        end else if (clearReq) begin
                            if (length == '0) begin
                                done <= 1'b1;
                            end else begin
                                ramAddr  <= startAddr;
                                wenReg   <= 1'b1;
                                wdataReg <= clearData;
                                remain   <= length - LEN_ONE;
                                state    <= CLEAR;
                            end
`endif
                        end
                    end
                    READ: begin
                        if (canIssue) begin
                            ramAddr    <= ramAddr + ADDR_ONE;
                            issueStage <= 1'b1;
                            remain     <= remain - LEN_ONE;
                            if (remain == LEN_ONE) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (pop && fifoCount == '0 && !issueStage && !returnStage) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
`ifdef RAM_STREAM_CLEAR_EN
                    CLEAR: begin
                        if (remain == '0) begin
                            wenReg   <= 1'b0;
                            wdataReg <= '0;
                            state    <= IDLE;
                            done     <= 1'b1;
                        end else begin
                            ramAddr <= ramAddr + ADDR_ONE;
                            remain  <= remain - LEN_ONE;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a registered-read RAM model preloaded with mem[i]=i.
module tb_ram_stream_reader;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] startAddr;
    logic [8:0] length;
    logic       abort;
    logic [7:0] ramAddr;
    logic       ramWEn;
    logic [7:0] ramDataIn;
    logic [7:0] ramDataOut;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic       busy;
    logic       done;
`ifdef RAM_STREAM_CLEAR_EN
    logic       clearReq;
    logic [7:0] clearData;
`endif

    logic [7:0] mem [256];
    int testsRun    = 0;
    int testsFailed = 0;

    ram_stream_reader #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .startAddr  (startAddr),
        .length     (length),
        .abort      (abort),
`ifdef RAM_STREAM_CLEAR_EN
        .clearReq   (clearReq),
        .clearData  (clearData),
`endif
        .ramAddr    (ramAddr),
        .ramWEn     (ramWEn),
        .ramDataIn  (ramDataIn),
        .ramDataOut (ramDataOut),
        .outData    (outData),
        .outValid   (outValid),
        .outReady   (outReady),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            ramDataOut <= '0;
        end else begin
            if (ramWEn) mem[ramAddr] <= ramDataIn;
            ramDataOut <= mem[ramAddr];
        end
    end

    task automatic applyStimulus(input logic s, input logic [7:0] a, input logic [8:0] l, input logic ab);
        start     = s;
        startAddr = a;
        length    = l;
        abort     = ab;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Runs one burst with outReady=1 except an optional stall window, checking every accepted word.
    task automatic runBurst(input logic [7:0] addr, input int len, input int stallAt, input int stallLen,
                            input bit extraStart, input string tag);
        int         got      = 0;
        int         stalled  = 0;
        int         addrErr  = 0;
        int         heldErr  = 0;
        bit         doneSeen = 1'b0;
        logic [7:0] prevAddr;
        logic [7:0] heldData = '0;
        logic [7:0] expData;
        outReady = 1'b1;
        applyStimulus(1'b1, addr, 9'(len), 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, addr, 9'(len), 1'b0);
        checkOutput({tag, "_firstAddr"}, 32'(ramAddr), 32'(addr));
        prevAddr = addr;
        for (int cyc = 1; cyc < 80 && !doneSeen; cyc++) begin
            if (extraStart && cyc == 2) applyStimulus(1'b1, 8'h80, 9'd3, 1'b0);
            else if (extraStart && cyc == 3) applyStimulus(1'b0, addr, 9'(len), 1'b0);
            if (ramAddr != prevAddr && ramAddr != prevAddr + 8'd1) addrErr++;
            if (stallLen > 0 && got >= stallAt && stalled < stallLen) begin
                outReady = 1'b0;
                if (stalled == 0) heldData = outData;
                else if (outData !== heldData || outValid !== 1'b1) heldErr++;
                if (stalled >= 2 && ramAddr != prevAddr) heldErr++;
                stalled++;
            end else begin
                outReady = 1'b1;
            end
            if (outReady && outValid) begin
                expData = addr + 8'(got);
                checkOutput({tag, "_word"}, 32'(outData), 32'(expData));
                got++;
            end
            if (done) doneSeen = 1'b1;
            prevAddr = ramAddr;
            @(negedge clk);
        end
        outReady = 1'b1;
        checkOutput({tag, "_count"}, 32'(got), 32'(len));
        checkOutput({tag, "_doneSeen"}, 32'(doneSeen), 32'd1);
        checkOutput({tag, "_addrSeq"}, 32'(addrErr), 32'd0);
        checkOutput({tag, "_afterDone"}, {30'd0, done, outValid}, 32'd0);
        if (stallLen > 0) checkOutput({tag, "_held"}, 32'(heldErr), 32'd0);
    endtask

    initial begin
        int         idleErr;
        logic [7:0] expData;
        resetn   = 1'b0;
        outReady = 1'b1;
        applyStimulus(1'b0, 8'h00, 9'd0, 1'b0);
`ifdef RAM_STREAM_CLEAR_EN
        clearReq  = 1'b0;
        clearData = 8'h00;
`endif
        repeat (3) @(negedge clk);
        checkOutput("reset_ramAddr", 32'(ramAddr), 32'h0);
        checkOutput("reset_ramWEn", 32'(ramWEn), 32'h0);
        checkOutput("reset_ramDataIn", 32'(ramDataIn), 32'h0);
        checkOutput("reset_outValid", 32'(outValid), 32'h0);
        checkOutput("reset_outData", 32'(outData), 32'h0);
        checkOutput("reset_busy_done", {30'd0, busy, done}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // Cycle-exact burst: words in cycles 3..6, done in cycle 7.
        applyStimulus(1'b1, 8'h10, 9'd4, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 8'h10, 9'd4, 1'b0);
        checkOutput("lat_c1_ramAddr", 32'(ramAddr), 32'h10);
        checkOutput("lat_c1_busy", 32'(busy), 32'h1);
        checkOutput("lat_c1_outValid", 32'(outValid), 32'h0);
        @(negedge clk);
        checkOutput("lat_c2_outValid", 32'(outValid), 32'h0);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            expData = 8'h10 + 8'(c - 3);
            checkOutput("lat_outValid", 32'(outValid), 32'h1);
            checkOutput("lat_outData", 32'(outData), 32'(expData));
            checkOutput("lat_noEarlyDone", 32'(done), 32'h0);
        end
        @(negedge clk);
        checkOutput("lat_c7_done", 32'(done), 32'h1);
        checkOutput("lat_c7_busy_valid", {30'd0, busy, outValid}, 32'h0);
        @(negedge clk);
        checkOutput("lat_c8_done", 32'(done), 32'h0);

        runBurst(8'hFE, 4, 0, 0, 1'b0, "wrap");
        runBurst(8'h40, 8, 1, 5, 1'b0, "stall");

        // Zero-length start: no read, done next cycle, address held at 0x47.
        applyStimulus(1'b1, 8'h99, 9'd0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 8'h99, 9'd0, 1'b0);
        checkOutput("len0_done", 32'(done), 32'h1);
        checkOutput("len0_busy", 32'(busy), 32'h0);
        checkOutput("len0_ramAddr", 32'(ramAddr), 32'h47);
        @(negedge clk);
        checkOutput("len0_doneOnce", {30'd0, busy, done}, 32'h0);

        runBurst(8'h30, 2, 0, 0, 1'b1, "busyStart");

        // Abort while the third word is on the output.
        applyStimulus(1'b1, 8'h50, 9'd6, 1'b0);
        repeat (5) begin
            @(negedge clk);
            applyStimulus(1'b0, 8'h50, 9'd6, 1'b0);
        end
        checkOutput("abort_word3", 32'(outData), 32'h52);
        applyStimulus(1'b0, 8'h50, 9'd6, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 8'h50, 9'd6, 1'b0);
        checkOutput("abort_state", {29'd0, busy, outValid, done}, 32'h0);
        idleErr = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || outValid || done) idleErr++;
        end
        checkOutput("abort_quiet", 32'(idleErr), 32'h0);

        // Reset while the third word is on the output.
        applyStimulus(1'b1, 8'h60, 9'd6, 1'b0);
        repeat (5) begin
            @(negedge clk);
            applyStimulus(1'b0, 8'h60, 9'd6, 1'b0);
        end
        checkOutput("rst_word3", 32'(outData), 32'h62);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        checkOutput("rst_state", {29'd0, busy, outValid, done}, 32'h0);
        checkOutput("rst_ramAddr", 32'(ramAddr), 32'h0);
        checkOutput("rst_outData", 32'(outData), 32'h0);
        idleErr = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || outValid || done) idleErr++;
        end
        checkOutput("rst_quiet", 32'(idleErr), 32'h0);

`ifdef RAM_STREAM_CLEAR_EN
        applyStimulus(1'b0, 8'h20, 9'd3, 1'b0);
        clearReq  = 1'b1;
        clearData = 8'hAA;
        @(negedge clk);
        clearReq = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            expData = 8'h1F + 8'(c);
            checkOutput("clr_wen", 32'(ramWEn), 32'h1);
            checkOutput("clr_addr", 32'(ramAddr), 32'(expData));
            checkOutput("clr_data", 32'(ramDataIn), 32'hAA);
            checkOutput("clr_noValid", 32'(outValid), 32'h0);
            @(negedge clk);
        end
        checkOutput("clr_end_wen", 32'(ramWEn), 32'h0);
        checkOutput("clr_end_done", 32'(done), 32'h1);
        @(negedge clk);
        applyStimulus(1'b1, 8'h20, 9'd3, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 8'h20, 9'd3, 1'b0);
        @(negedge clk);
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk);
            checkOutput("clr_readback", {23'd0, outValid, outData}, 32'h1AA);
        end
        @(negedge clk);
        checkOutput("clr_readback_done", 32'(done), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the RAM word width in bits.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 8, giving the RAM address width in bits.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 2, giving the output buffer entries; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle request to begin a burst.
REQ-007 The block SHALL have port startAddr, input, ADDRESS_WIDTH bits: first RAM address of the burst.
REQ-008 The block SHALL have port length, input, ADDRESS_WIDTH+1 bits: word count, 0 to 2^ADDRESS_WIDTH.
REQ-009 The block SHALL have port abort, input, 1 bit: flush and return to IDLE.
REQ-010 The block SHALL have port ramAddr, output, ADDRESS_WIDTH bits: address presented to the RAM.
REQ-011 The block SHALL have port ramWEn, output, 1 bit: write enable to the RAM.
REQ-012 The block SHALL have port ramDataIn, output, DATA_WIDTH bits: write data to the RAM.
REQ-013 The block SHALL have port ramDataOut, input, DATA_WIDTH bits: registered RAM read data, valid one cycle after the read address.
REQ-014 The block SHALL have ports outData (output, DATA_WIDTH), outValid (output, 1) and outReady (input, 1): the downstream stream.
REQ-015 The block SHALL have ports busy (output, 1), high when not IDLE, and done (output, 1), a one-cycle completion pulse.

Function
REQ-016 States SHALL be IDLE, READ and DRAIN; IDLE->READ on start with length>0; READ->DRAIN once the last read is issued; DRAIN->IDLE once the last word is accepted (outValid&&outReady).
REQ-017 Start with length 0 SHALL produce no reads and a done pulse on the next cycle, with the state staying IDLE.
REQ-018 Start while busy SHALL be ignored.
REQ-019 A read SHALL issue (ramWEn=0, new ramAddr) only when FIFO occupancy plus in-flight reads is less than FIFO_DEPTH.
REQ-020 Return data SHALL be written to the FIFO in the cycle after issue.
REQ-021 Latency: start sampled at edge 0 -> first ramAddr=startAddr during cycle 1 -> outValid=1 in cycle 3.
REQ-022 Throughput SHALL be one word per cycle while outReady=1.
REQ-023 The address SHALL increment by 1 per read, wrapping modulo 2^ADDRESS_WIDTH (0xFF->0x00 at default).
REQ-024 outData SHALL be stable while outValid=1 and outReady=0; words SHALL be delivered in address order, never lost or duplicated.
REQ-025 Full FIFO SHALL stall reads; an empty FIFO SHALL hold outValid=0.
REQ-026 FIFO read and write in the same cycle SHALL leave occupancy unchanged.
REQ-027 done SHALL pulse in the cycle after the final handshake.
REQ-028 abort SHALL take precedence over start: next cycle state=IDLE, FIFO empty, in-flight data discarded, no done pulse.
REQ-029 When idle, ramAddr SHALL hold its last value, ramWEn=0 and ramDataIn=0.

Reset
REQ-030 While resetn=0 at a clock edge, the block SHALL enter IDLE with FIFO and in-flight count cleared.
REQ-031 Reset values SHALL be: ramAddr=0, ramWEn=0, ramDataIn=0, outValid=0, outData=0, busy=0, done=0.
REQ-032 Reset mid-burst SHALL abandon the burst without emitting done.

Configuration
REQ-033 Macro RAM_STREAM_CLEAR_EN defined SHALL add inputs clearReq (1 bit) and clearData (DATA_WIDTH bits) and a CLEAR state.
REQ-034 With RAM_STREAM_CLEAR_EN, clearReq in IDLE SHALL write clearData to length words from startAddr, one per cycle with ramWEn=1, wrapping per REQ-023, then pulse done; outValid SHALL stay 0 throughout; start SHALL win over a simultaneous clearReq; abort SHALL stop clearing immediately.
REQ-035 Without RAM_STREAM_CLEAR_EN, clearReq, clearData and CLEAR SHALL be absent, and ramWEn and ramDataIn SHALL be constant 0.

Verification
REQ-036 Bench: RAM preloaded with mem[i]=i, start startAddr=0x10 length=4, outReady=1 -> outData 0x10,0x11,0x12,0x13 in cycles 3-6, done in cycle 7.
REQ-037 Bench: startAddr=0xFE length=4 -> outData 0xFE,0xFF,0x00,0x01.
REQ-038 Bench: outReady=0 for 5 cycles mid-burst -> at most 2 reads outstanding, outData held, all 8 words in order.
REQ-039 Bench: length=0 -> no ramAddr change, done pulse next cycle, busy stays 0; start while busy -> ignored.
REQ-040 Bench: abort or resetn=0 on the 3rd word -> IDLE next cycle, outValid=0, no done.
REQ-041 Bench (RAM_STREAM_CLEAR_EN): clearReq startAddr=0x20 length=3 clearData=0xAA -> ramWEn=1 three cycles at 0x20-0x22, then read-back returns 0xAA x3.
